// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the RV32IM pipeline hazard controller.
// Holds the FSM state encoding and the forwarding mux select codes.
package hazard_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        DIV_BUSY = 1'b1
    } hz_state_t;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-side signals seen by the hazard controller.
// Divider handshake: DivStart is a one-cycle request; DivDone is a one-cycle completion pulse, honoured only while busy.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import hazard_pkg::*;

    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    logic             MemReadE;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             PCSrcE;
    logic             DivE;
    logic             DivDone;
    logic             DivStart;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             StallE;
    logic             FlushE;
    logic             FlushM;
    logic             DivTimeout;
    logic [CNT_W-1:0] StallCount;
    hz_state_t        state;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output MemReadE, RegWriteM, RegWriteW, PCSrcE, DivE, DivDone,
        input  DivStart, ForwardAE, ForwardBE, StallF, StallD, FlushD,
        input  StallE, FlushE, FlushM, DivTimeout, StallCount, state
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  MemReadE, RegWriteM, RegWriteW, PCSrcE, DivE, DivDone,
        output DivStart, ForwardAE, ForwardBE, StallF, StallD, FlushD,
        output StallE, FlushE, FlushM, DivTimeout, StallCount, state
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// Forwarding select for one EX-stage source operand.
// The MEM-stage producer is younger than WB, so it wins when both match.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_mem,
    input  logic [4:0] rd_wb,
    input  logic       reg_write_mem,
    input  logic       reg_write_wb,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_NONE;
        if (reg_write_mem && (rd_mem != 5'd0) && (rd_mem == rs)) begin
            sel = FWD_MEM;
        end else if (reg_write_wb && (rd_wb != 5'd0) && (rd_wb == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller: forwarding, load-use stalls, branch flushes
// and the stall/release sequence around the external multi-cycle divider.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam int              WD_W   = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(DIV_TIMEOUT - 1);

    hz_state_t        state;
    hz_state_t        state_next;
    logic [WD_W-1:0]  wd_cnt;
    logic             timeout_flag;
    logic [CNT_W-1:0] stall_cnt;

    logic lw_stall;
    logic div_go;
    logic wd_hit;
    logic div_release;

    logic div_start;
    logic stall_f;
    logic stall_d;
    logic flush_d;
    logic stall_e;
    logic flush_e;
    logic flush_m;

    fwd_sel u_fwd_a (
        .rs            (hz.Rs1E),
        .rd_mem        (hz.RdM),
        .rd_wb         (hz.RdW),
        .reg_write_mem (hz.RegWriteM),
        .reg_write_wb  (hz.RegWriteW),
        .sel           (hz.ForwardAE)
    );

    fwd_sel u_fwd_b (
        .rs            (hz.Rs2E),
        .rd_mem        (hz.RdM),
        .rd_wb         (hz.RdW),
        .reg_write_mem (hz.RegWriteM),
        .reg_write_wb  (hz.RegWriteW),
        .sel           (hz.ForwardBE)
    );

    assign lw_stall = hz.MemReadE && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    // A taken branch kills the divide in EX, so it must not launch one.
    assign div_go      = (state == IDLE) && hz.DivE && !hz.PCSrcE;
    assign wd_hit      = (state == DIV_BUSY) && (wd_cnt == WD_MAX);
    assign div_release = (state == DIV_BUSY) && (hz.DivDone || wd_hit);

    always_comb begin
        div_start  = 1'b0;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        flush_d    = 1'b0;
        stall_e    = 1'b0;
        flush_e    = 1'b0;
        flush_m    = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (div_go) begin
                    div_start  = rst_n;
                    stall_f    = 1'b1;
                    stall_d    = 1'b1;
                    stall_e    = 1'b1;
                    flush_m    = 1'b1;
                    state_next = DIV_BUSY;
                end else begin
                    stall_f = lw_stall;
                    stall_d = lw_stall;
                    flush_e = lw_stall || hz.PCSrcE;
                    flush_d = hz.PCSrcE;
                end
            end
            DIV_BUSY: begin
                // On release everything drops so the divide moves into MEM with its result.
                if (div_release) begin
                    state_next = IDLE;
                end else begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (div_go) begin
            wd_cnt <= '0;
        end else if ((state == DIV_BUSY) && !div_release) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // A real DivDone on the final watchdog cycle is a normal completion, not a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_flag <= 1'b0;
        end else if (wd_hit && !hz.DivDone) begin
            timeout_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_f) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign hz.DivStart   = div_start;
    assign hz.StallF     = stall_f;
    assign hz.StallD     = stall_d;
    assign hz.FlushD     = flush_d;
    assign hz.StallE     = stall_e;
    assign hz.FlushE     = flush_e;
    assign hz.FlushM     = flush_m;
    assign hz.DivTimeout = timeout_flag;
    assign hz.StallCount = stall_cnt;
    assign hz.state      = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a default instance and a
// DIV_TIMEOUT=8 instance share the same stimulus; each phase checks one of them.
module tb_pipeline_hazard_ctrl;
    import hazard_pkg::*;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [12:0] exp_q[$];
    logic [31:0] exp_cnt64;
    logic [31:0] exp_cnt8;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) hz  ();
    pipeline_hazard_ctrl_if #(.CNT_W(32)) hz8 ();

    pipeline_hazard_ctrl #(.DIV_TIMEOUT(64), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz.slave)
    );

    pipeline_hazard_ctrl #(.DIV_TIMEOUT(8), .CNT_W(32)) dut_wd (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz8.slave)
    );

    assign hz8.Rs1D      = hz.Rs1D;
    assign hz8.Rs2D      = hz.Rs2D;
    assign hz8.Rs1E      = hz.Rs1E;
    assign hz8.Rs2E      = hz.Rs2E;
    assign hz8.RdE       = hz.RdE;
    assign hz8.RdM       = hz.RdM;
    assign hz8.RdW       = hz.RdW;
    assign hz8.MemReadE  = hz.MemReadE;
    assign hz8.RegWriteM = hz.RegWriteM;
    assign hz8.RegWriteW = hz.RegWriteW;
    assign hz8.PCSrcE    = hz.PCSrcE;
    assign hz8.DivE      = hz.DivE;
    assign hz8.DivDone   = hz.DivDone;

    // {state, DivStart, ForwardAE, ForwardBE, StallF, StallD, FlushD, StallE, FlushE, FlushM, DivTimeout}
    logic [12:0] obs64;
    logic [12:0] obs8;
    assign obs64 = {hz.state, hz.DivStart, hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD,
                    hz.FlushD, hz.StallE, hz.FlushE, hz.FlushM, hz.DivTimeout};
    assign obs8  = {hz8.state, hz8.DivStart, hz8.ForwardAE, hz8.ForwardBE, hz8.StallF, hz8.StallD,
                    hz8.FlushD, hz8.StallE, hz8.FlushE, hz8.FlushM, hz8.DivTimeout};

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit exceeded");
    end

    function automatic logic [12:0] mk(logic st, logic ds, logic [1:0] fa, logic [1:0] fb,
                                       logic sf, logic sd, logic fd, logic se, logic fe,
                                       logic fm, logic to);
        return {st, ds, fa, fb, sf, sd, fd, se, fe, fm, to};
    endfunction

    function automatic logic [1:0] fwd_model(logic [4:0] rs, logic [4:0] rdm, logic [4:0] rdw,
                                             logic rwm, logic rww);
        if (rwm && rdm != 0 && rdm == rs) return 2'b10;
        if (rww && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    logic [12:0] w_zero;
    logic [12:0] w_start;
    logic [12:0] w_busy;
    logic [12:0] w_rel;
    initial begin
        w_zero  = mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        w_start = mk(1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        w_busy  = mk(1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        w_rel   = mk(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic clear_inputs();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
        hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
        hz.MemReadE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.PCSrcE = 1'b0; hz.DivE = 1'b0; hz.DivDone = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        check("rst_ctrl64", 32'(obs64), 32'(w_zero));
        check("rst_ctrl8", 32'(obs8), 32'(w_zero));
        check("rst_cnt64", hz.StallCount, 32'd0);
        check("rst_cnt8", hz8.StallCount, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt64 = '0;
        exp_cnt8  = '0;
        @(posedge clk);
        #1;
    endtask

    // One clock of scoreboarded checking; inputs must already be driven.
    task automatic cycle(input bit use8, input logic [12:0] e);
        logic [12:0] exp_w;
        exp_q.push_back(e);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        if (use8) begin
            check("ctrl8", 32'(obs8), 32'(exp_w));
            check("stall_count8", hz8.StallCount, exp_cnt8);
            if (exp_w[6]) exp_cnt8++;
        end else begin
            check("ctrl64", 32'(obs64), 32'(exp_w));
            check("stall_count64", hz.StallCount, exp_cnt64);
            if (exp_w[6]) exp_cnt64++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] fa;
        logic [1:0] fb;
        exp_cnt64 = '0;
        exp_cnt8  = '0;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        do_reset();

        // Forwarding, directed cases
        hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.Rs1E = 5'd5; hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
        cycle(0, mk(1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        hz.RegWriteM = 1'b0;
        cycle(0, mk(1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        hz.RegWriteM = 1'b1; hz.Rs1E = 5'd0; hz.RdM = 5'd0;
        cycle(0, w_zero);
        hz.Rs1E = 5'd3; hz.RdM = 5'd3; hz.Rs2E = 5'd4; hz.RdW = 5'd4;
        cycle(0, mk(1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        hz.Rs2E = 5'd3;
        cycle(0, mk(1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Forwarding, random cases
        for (int i = 0; i < 24; i++) begin
            hz.Rs1E = 5'($urandom_range(0, 7));
            hz.Rs2E = 5'($urandom_range(0, 7));
            hz.RdM  = 5'($urandom_range(0, 7));
            hz.RdW  = 5'($urandom_range(0, 7));
            hz.RegWriteM = 1'($urandom_range(0, 1));
            hz.RegWriteW = 1'($urandom_range(0, 1));
            fa = fwd_model(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
            fb = fwd_model(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
            cycle(0, mk(1'b0, 1'b0, fa, fb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        clear_inputs();

        // Load-use
        hz.MemReadE = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7; hz.Rs1D = 5'd3;
        cycle(0, mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        hz.RdE = 5'd0; hz.Rs1D = 5'd0; hz.Rs2D = 5'd0;
        cycle(0, w_zero);
        hz.MemReadE = 1'b0; hz.RdE = 5'd7; hz.Rs1D = 5'd7;
        cycle(0, w_zero);
        check("lu_count", hz.StallCount, 32'd1);

        // Branch
        clear_inputs();
        hz.PCSrcE = 1'b1;
        cycle(0, mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        hz.DivE = 1'b1;
        cycle(0, mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        clear_inputs();
        cycle(0, w_zero);
        hz.PCSrcE = 1'b1; hz.MemReadE = 1'b1; hz.RdE = 5'd9; hz.Rs1D = 5'd9;
        cycle(0, mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        clear_inputs();
        cycle(0, w_zero);

        // Divide with DivDone 10 cycles after start, then back-to-back
        do_reset();
        hz.DivE = 1'b1;
        cycle(0, w_start);
        for (int i = 0; i < 9; i++) cycle(0, w_busy);
        hz.DivDone = 1'b1;
        cycle(0, w_rel);
        hz.DivDone = 1'b0;
        check("div_count", hz.StallCount, 32'd10);
        cycle(0, w_start);
        cycle(0, w_busy);
        cycle(0, w_busy);
        hz.DivDone = 1'b1;
        cycle(0, w_rel);
        clear_inputs();
        cycle(0, w_zero);
        check("b2b_count", hz.StallCount, 32'd13);

        // Watchdog (DIV_TIMEOUT=8): DivDone on the timeout cycle first
        do_reset();
        hz.DivE = 1'b1;
        cycle(1, w_start);
        for (int i = 0; i < 7; i++) cycle(1, w_busy);
        hz.DivDone = 1'b1;
        cycle(1, w_rel);
        clear_inputs();
        cycle(1, w_zero);
        cycle(1, w_zero);

        // Then a divide that never completes
        hz.DivE = 1'b1;
        cycle(1, w_start);
        for (int i = 0; i < 7; i++) cycle(1, w_busy);
        cycle(1, w_rel);
        clear_inputs();
        cycle(1, w_zero | 13'd1);
        cycle(1, w_zero | 13'd1);
        check("wd_count", hz8.StallCount, 32'd16);
        hz.DivE = 1'b1;
        cycle(1, w_start | 13'd1);
        cycle(1, w_busy | 13'd1);
        hz.DivDone = 1'b1;
        cycle(1, w_rel | 13'd1);
        clear_inputs();
        cycle(1, w_zero | 13'd1);

        // Asynchronous reset mid-divide
        hz.DivE = 1'b1;
        cycle(1, w_start | 13'd1);
        cycle(1, w_busy | 13'd1);
        cycle(1, w_busy | 13'd1);
        #2;
        rst_n = 1'b0;
        hz.DivE = 1'b0;
        #1;
        check("arst_state", 32'(hz8.state), 32'(IDLE));
        check("arst_stall", 32'(hz8.StallF), 32'd0);
        check("arst_flushm", 32'(hz8.FlushM), 32'd0);
        check("arst_count", hz8.StallCount, 32'd0);
        check("arst_timeout", 32'(hz8.DivTimeout), 32'd0);
        check("arst_count64", hz.StallCount, 32'd0);
        hz.DivE = 1'b1;
        #1;
        check("arst_divstart", 32'(hz8.DivStart), 32'd0);
        check("arst_divstart64", 32'(hz.DivStart), 32'd0);
        check("arst_idle_stall", 32'(hz8.StallF), 32'd1);
        @(posedge clk);
        #1;
        check("arst_hold_state", 32'(hz8.state), 32'(IDLE));
        check("arst_hold_count", hz8.StallCount, 32'd0);
        do_reset();

        hz.DivE = 1'b1;
        cycle(0, w_start);
        hz.DivDone = 1'b1;
        cycle(0, w_rel);
        clear_inputs();
        cycle(0, w_zero);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the RV32IM 5-stage pipeline.
- Drives the en/clr controls of the IF/ID, ID/EX and EX/MEM pipeline registers. Handles load-use stalls, taken-branch flushes and EX-stage operand forwarding.
- Runs the start/done handshake with the external multi-cycle divider. Holds the front of the pipeline while the divider is busy, with a watchdog timeout and a stall-cycle performance counter.

Parameters:
- DIV_TIMEOUT, 64, max cycles in DIV_BUSY before the watchdog aborts the divide (minimum 2).
- CNT_W, 32, width of the StallCount performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Rs1D  in  5  ID-stage rs1.
- Rs2D  in  5  ID-stage rs2.
- Rs1E  in  5  EX-stage rs1.
- Rs2E  in  5  EX-stage rs2.
- RdE  in  5  EX-stage rd.
- RdM  in  5  MEM-stage rd.
- RdW  in  5  WB-stage rd.
- MemReadE  in  1  EX-stage instruction is a load.
- RegWriteM  in  1  MEM-stage instruction writes the register file.
- RegWriteW  in  1  WB-stage instruction writes the register file.
- PCSrcE  in  1  taken branch or jump resolved in EX.
- DivE  in  1  EX-stage instruction is DIV/DIVU/REM/REMU.
- DivDone  in  1  divider result valid (single-cycle pulse).
- DivStart  out  1  divider start pulse.
- ForwardAE  out  2  EX operand A mux select.
- ForwardBE  out  2  EX operand B mux select.
- StallF  out  1  hold PC.
- StallD  out  1  IF/ID en low.
- FlushD  out  1  IF/ID clr.
- StallE  out  1  ID/EX en low.
- FlushE  out  1  ID/EX clr.
- FlushM  out  1  EX/MEM clr (bubble insertion).
- DivTimeout  out  1  sticky watchdog flag.
- StallCount  out  CNT_W  number of cycles with StallF=1.

Behaviour:
- Forwarding (combinational):
  - ForwardAE = 2'b10 if RegWriteM and RdM!=0 and RdM==Rs1E.
  - Otherwise ForwardAE = 2'b01 if RegWriteW and RdW!=0 and RdW==Rs1E.
  - Otherwise ForwardAE = 2'b00.
  - ForwardBE uses the same rules with Rs2E. MEM has priority over WB.
- lwStall = MemReadE and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
- FSM states are IDLE, DIV_BUSY. Reset state is IDLE.
- IDLE:
  - If DivE=1 and PCSrcE=0: DivStart=1 for this cycle only; StallF=StallD=StallE=1; FlushM=1; next state DIV_BUSY; clear the watchdog counter.
  - Otherwise StallE=0 and FlushM=0; StallF=StallD=lwStall; FlushE=lwStall or PCSrcE; FlushD=PCSrcE.
  - DivDone is ignored in IDLE.
- DIV_BUSY:
  - StallF=StallD=StallE=1, FlushM=1, DivStart=0, FlushD=FlushE=0.
  - The watchdog counter increments each cycle.
  - On DivDone=1: release all stalls and flushes in that same cycle so the divide advances into MEM with its result; next state IDLE.
  - If the counter reaches DIV_TIMEOUT-1 without DivDone: DivTimeout<=1 (sticky until reset); release as for DivDone; next state IDLE.
- DivDone and timeout in the same cycle: treat as DivDone; DivTimeout is not set.
- Back-to-back divides: the cycle after release, the new EX instruction with DivE=1 triggers a fresh DivStart from IDLE.
- StallCount increments by 1 on every cycle with StallF=1 and wraps modulo 2^CNT_W.
- Reset (rst_n=0, asynchronous, any state including mid-divide):
  - state=IDLE, watchdog counter=0, DivTimeout=0, StallCount=0.
  - DivStart is forced to 0 while reset is asserted.
  - Combinational outputs follow the IDLE equations.

Decomposition:
- Shared package hazard_pkg holds:
  - typedef enum logic {IDLE, DIV_BUSY} hz_state_t;
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One sub-module, fwd_sel: the combinational forwarding select for a single operand, instantiated twice (A and B).

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, Rs1E=5, RdW=5, RegWriteW=1 -> ForwardAE=2'b10. Same with RegWriteM=0 -> 2'b01. Rs1E=0 with RdM=0 -> 2'b00.
- Load-use: MemReadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, StallCount +1. RdE=0 -> no stall.
- Branch: PCSrcE=1 -> FlushD=FlushE=1 and no stall. PCSrcE=1 with DivE=1 -> no DivStart; state stays IDLE.
- Divide: DivE=1, DivDone pulsed 10 cycles later -> DivStart high exactly 1 cycle; stalls and FlushM high for 10 cycles; released on the DivDone cycle; StallCount=10. Back-to-back DIV -> second DivStart the cycle after release.
- Watchdog: DIV_TIMEOUT=8, DivDone never asserted -> release after 8 stall cycles, DivTimeout=1 and sticky. DivDone coinciding with the timeout cycle -> DivTimeout stays 0.
- Reset mid-divide: rst_n low in DIV_BUSY -> state IDLE, stalls drop, DivStart=0, StallCount=0 and DivTimeout=0 immediately, without waiting for a clock edge.
